// File: rtl/pcie_pcs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pcie_pcs_pkg
// Purpose  : Definitions shared by the PCS scrambler and descrambler:
//            the keystream reset seed, the 16-bit LFSR step function and
//            the lock-tracking state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package pcie_pcs_pkg;

    localparam logic [15:0] LFSR_SEED = 16'hFFFF;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } desc_state_e;

    // One keystream advance: shift left, feed back bit15 ^ bit14.
    function automatic logic [15:0] lfsr_step(input logic [15:0] lfsr);
        return {lfsr[14:0], lfsr[15] ^ lfsr[14]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/pcie_desc_lock_fsm.sv
`default_nettype none
// ============================================================================
// Module   : pcie_desc_lock_fsm
// Purpose  : Tracks keystream lock from the idle-beat check results.
// Ports    : clk, rst_n        - clock, async active-low reset
//            accept_i          - a beat is consumed this cycle
//            seed_i, idle_i    - flags of that beat
//            match_i           - descrambled beat equals all zeros
//            locked_o          - state is LOCKED (registered)
//            err_cnt_o         - saturating idle-mismatch count in LOCKED
// Revision : 1.0 - initial release
// ============================================================================
module pcie_desc_lock_fsm
    import pcie_pcs_pkg::*;
#(
    parameter int LOCK_CNT = 4,
    parameter int ERR_MAX  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       accept_i,
    input  logic       seed_i,
    input  logic       idle_i,
    input  logic       match_i,
    output logic       locked_o,
    output logic [7:0] err_cnt_o
);

    localparam int          c_CNT_W    = 8;
    localparam logic [7:0]  c_LOCK_CNT = c_CNT_W'(LOCK_CNT);
    localparam logic [7:0]  c_ERR_MAX  = c_CNT_W'(ERR_MAX);

    desc_state_e state_q, state_d;
    logic [7:0]  mcnt_q, mcnt_d;   // consecutive-ish matching idles in VERIFY
    logic [7:0]  ecnt_q, ecnt_d;   // consecutive idle mismatches in LOCKED
    logic [7:0]  err_q, err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEARCH;
            mcnt_q  <= '0;
            ecnt_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            mcnt_q  <= mcnt_d;
            ecnt_q  <= ecnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mcnt_d  = mcnt_q;
        ecnt_d  = ecnt_q;
        err_d   = err_q;
        if (accept_i) begin
            case (state_q)
                SEARCH: begin
                    // Only a seed beat can start a verification window; the
                    // seed beat itself counts if it is a clean idle.
                    if (seed_i) begin
                        mcnt_d  = (idle_i && match_i) ? 8'd1 : 8'd0;
                        state_d = (idle_i && match_i && (8'd1 >= c_LOCK_CNT))
                                  ? LOCKED : VERIFY;
                        ecnt_d  = '0;
                    end
                end
                VERIFY: begin
                    // Non-idle beats leave the counter untouched.
                    if (idle_i) begin
                        if (match_i) begin
                            mcnt_d = mcnt_q + 8'd1;
                            if (mcnt_d >= c_LOCK_CNT) begin
                                state_d = LOCKED;
                                ecnt_d  = '0;
                            end
                        end else begin
                            state_d = SEARCH;
                            mcnt_d  = '0;
                        end
                    end
                end
                LOCKED: begin
                    if (idle_i) begin
                        if (match_i) begin
                            ecnt_d = '0;
                        end else begin
                            ecnt_d = ecnt_q + 8'd1;
                            if (err_q != 8'hFF) begin
                                err_d = err_q + 8'd1;
                            end
                            if (ecnt_d >= c_ERR_MAX) begin
                                state_d = SEARCH;
                                ecnt_d  = '0;
                                mcnt_d  = '0;
                            end
                        end
                    end
                end
                default: begin
                    state_d = SEARCH;
                    mcnt_d  = '0;
                    ecnt_d  = '0;
                end
            endcase
        end
    end

    assign locked_o  = (state_q == LOCKED);
    assign err_cnt_o = err_q;

endmodule
`default_nettype wire

// File: rtl/pcie_descrambler.sv
`default_nettype none
// ============================================================================
// Module   : pcie_descrambler
// Purpose  : Removes the 16-bit LFSR keystream from 128-bit RX beats,
//            re-seeds on seed markers, tracks lock on idle beats and
//            presents results through a one-deep registered valid/ready stage.
// Ports    : clk, rst_n                 - clock, async active-low reset
//            in_valid_i/in_ready_o      - upstream handshake
//            in_data_i                  - scrambled beat
//            in_seed_i, in_idle_i       - beat flags (qualified by valid)
//            out_valid_o/out_ready_i    - downstream handshake
//            out_data_o                 - descrambled beat
//            locked_o, err_cnt_o        - lock status and error count
// Revision : 1.0 - initial release
// ============================================================================
module pcie_descrambler
    import pcie_pcs_pkg::*;
#(
    parameter int LOCK_CNT = 4,
    parameter int ERR_MAX  = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [127:0] in_data_i,
    input  logic         in_seed_i,
    input  logic         in_idle_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] out_data_o,
    output logic         locked_o,
    output logic [7:0]   err_cnt_o
);

    logic [15:0]  lfsr_q, lfsr_d;
    logic [127:0] out_data_q, out_data_d;
    logic         out_valid_q, out_valid_d;

    logic         w_accept;
    logic [15:0]  w_key;
    logic [127:0] w_desc;
    logic         w_match;

    // The output register frees up in the same cycle it is drained.
    assign in_ready_o = !out_valid_q || out_ready_i;
    assign w_accept   = in_valid_i && in_ready_o;

    // A seed beat is itself keyed with the reset seed, not the running LFSR.
    assign w_key   = in_seed_i ? LFSR_SEED : lfsr_q;
    assign w_desc  = in_data_i ^ {8{w_key}};
    assign w_match = (w_desc == '0);

    always_comb begin
        lfsr_d      = lfsr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (w_accept) begin
            lfsr_d      = lfsr_step(w_key);
            out_data_d  = w_desc;
            out_valid_d = 1'b1;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q      <= LFSR_SEED;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            lfsr_q      <= lfsr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;

    pcie_desc_lock_fsm #(
        .LOCK_CNT (LOCK_CNT),
        .ERR_MAX  (ERR_MAX)
    ) u_lock_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .accept_i  (w_accept),
        .seed_i    (in_seed_i),
        .idle_i    (in_idle_i),
        .match_i   (w_match),
        .locked_o  (locked_o),
        .err_cnt_o (err_cnt_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_pcie_descrambler.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcie_descrambler
// Purpose  : Self-checking bench for pcie_descrambler with a behavioural
//            keystream / lock model.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcie_descrambler;

    localparam int LOCK_CNT = 4;
    localparam int ERR_MAX  = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic         in_seed = 1'b0;
    logic         in_idle = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] out_data;
    logic         locked;
    logic [7:0]   err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [15:0]  m_lfsr;
    int           m_state;   // 0 search, 1 verify, 2 locked
    int           m_mcnt;
    int           m_ecnt;
    int           m_err;
    logic [127:0] m_out;

    always #5 clk = ~clk;

    pcie_descrambler #(.LOCK_CNT(LOCK_CNT), .ERR_MAX(ERR_MAX)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_seed_i   (in_seed),
        .in_idle_i   (in_idle),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .locked_o    (locked),
        .err_cnt_o   (err_cnt)
    );

    function automatic logic [15:0] next_key(input logic [15:0] k);
        int v;
        v = int'(k);
        v = ((v * 2) % 65536) + (((v / 32768) + (v / 16384)) % 2);
        return 16'(v);
    endfunction

    function automatic logic [127:0] spread(input logic [15:0] k);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r = (r << 16) | 128'(k);
        return r;
    endfunction

    task automatic model_reset();
        m_lfsr  = 16'hFFFF;
        m_state = 0;
        m_mcnt  = 0;
        m_ecnt  = 0;
        m_err   = 0;
        m_out   = '0;
    endtask

    task automatic model_beat(input logic [127:0] d, input bit s, input bit idl);
        logic [15:0] key;
        bit          good;
        key    = s ? 16'hFFFF : m_lfsr;
        m_out  = d ^ spread(key);
        m_lfsr = next_key(key);
        good   = (m_out == 128'h0);
        if (m_state == 0) begin
            if (s) begin
                m_state = 1;
                m_mcnt  = (idl && good) ? 1 : 0;
                if (m_mcnt >= LOCK_CNT) m_state = 2;
            end
        end else if (m_state == 1) begin
            if (idl) begin
                if (good) begin
                    m_mcnt++;
                    if (m_mcnt >= LOCK_CNT) begin m_state = 2; m_ecnt = 0; end
                end else begin
                    m_state = 0;
                end
            end
        end else if (idl) begin
            if (good) m_ecnt = 0;
            else begin
                m_ecnt++;
                if (m_err < 255) m_err++;
                if (m_ecnt >= ERR_MAX) begin m_state = 0; m_ecnt = 0; end
            end
        end
    endtask

    // Ciphertext whose plaintext is all zeros under the key the next beat uses.
    function automatic logic [127:0] clean_idle(input bit s);
        return spread(s ? 16'hFFFF : m_lfsr);
    endfunction

    task automatic drive(input logic [127:0] d, input bit s, input bit idl);
        in_valid = 1'b1;
        in_data  = d;
        in_seed  = s;
        in_idle  = idl;
        @(posedge clk);
        model_beat(d, s, idl);
        #1;
        in_valid = 1'b0;
        in_seed  = 1'b0;
        in_idle  = 1'b0;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic lock_up();
        drive(clean_idle(1'b1), 1'b1, 1'b1);
        for (int i = 0; i < LOCK_CNT - 1; i++) drive(clean_idle(1'b0), 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++;
        if (out_data !== 128'h0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
        n_checks++;
        if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked got %b want 0", locked); end
        n_checks++;
        if (err_cnt !== 8'h0) begin n_fail++; $display("FAIL reset_err_cnt got %h want 0", err_cnt); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_seed_sequence();
        logic [15:0] keys [4];
        keys[0] = 16'hFFFF; keys[1] = 16'hFFFE; keys[2] = 16'hFFFC; keys[3] = 16'hFFF8;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(spread(keys[i]), i == 0, 1'b0);
            n_checks++;
            if (out_data !== 128'h0 || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL seed_seq[%0d] got %h/%b want 0/1", i, out_data, out_valid);
            end
        end
    endtask

    task automatic test_lock_acquire();
        logic exp_l [4];
        exp_l[0] = 1'b0; exp_l[1] = 1'b0; exp_l[2] = 1'b0; exp_l[3] = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(clean_idle(i == 0), i == 0, 1'b1);
            n_checks++;
            if (locked !== exp_l[i] || err_cnt !== 8'h0 || out_data !== 128'h0) begin
                n_fail++;
                $display("FAIL lock_acq[%0d] locked %b err %0d data %h want %b 0 0",
                         i, locked, err_cnt, out_data, exp_l[i]);
            end
        end
    endtask

    task automatic test_lock_loss();
        logic exp_l [3];
        exp_l[0] = 1'b1; exp_l[1] = 1'b1; exp_l[2] = 1'b0;
        do_reset();
        lock_up();
        drive({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(clean_idle(1'b0) ^ 128'h1, 1'b0, 1'b1);
            n_checks++;
            if (locked !== exp_l[i] || err_cnt !== 8'(i + 1) || out_data !== 128'h1) begin
                n_fail++;
                $display("FAIL lock_loss[%0d] locked %b err %0d data %h want %b %0d 1",
                         i, locked, err_cnt, out_data, exp_l[i], i + 1);
            end
        end
        drive(clean_idle(1'b0), 1'b0, 1'b1);
        n_checks++;
        if (locked !== 1'b0 || err_cnt !== 8'd3) begin
            n_fail++;
            $display("FAIL no_relock locked %b err %0d want 0 3", locked, err_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] b, held;
        do_reset();
        drive({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);
        drive({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
        held = m_out;
        b = {$urandom, $urandom, $urandom, $urandom};
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = b;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== held) begin
                n_fail++;
                $display("FAIL bp_hold[%0d] rdy %b vld %b data %h want 0 1 %h",
                         i, in_ready, out_valid, out_data, held);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        model_beat(b, 1'b0, 1'b0);
        #1;
        in_valid = 1'b0;
        n_checks++;
        if (out_data !== m_out || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_resume got %h want %h", out_data, m_out);
        end
        for (int i = 0; i < 3; i++) begin
            drive(128'h0123_4567_89AB_CDEF_0011_2233_4455_6677 + 128'(i), 1'b0, 1'b0);
            n_checks++;
            if (out_data !== m_out) begin
                n_fail++;
                $display("FAIL bp_after[%0d] got %h want %h", i, out_data, m_out);
            end
        end
    endtask

    task automatic test_reseed_locked();
        do_reset();
        lock_up();
        drive(128'hDEAD_BEEF, 1'b0, 1'b0);
        drive(spread(16'hFFFF), 1'b1, 1'b0);
        n_checks++;
        if (out_data !== 128'h0 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL reseed_beat data %h locked %b want 0 1", out_data, locked);
        end
        drive(spread(16'hFFFE), 1'b0, 1'b1);
        n_checks++;
        if (out_data !== 128'h0 || locked !== 1'b1 || err_cnt !== 8'h0) begin
            n_fail++;
            $display("FAIL reseed_next data %h locked %b err %0d want 0 1 0", out_data, locked, err_cnt);
        end
    endtask

    task automatic test_reset_midstream();
        logic [127:0] p;
        do_reset();
        lock_up();
        drive(clean_idle(1'b0) ^ 128'h80, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        drive({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
        n_checks++;
        if (out_valid !== 1'b1 || locked !== 1'b1 || err_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL pre_reset vld %b locked %b err %0d want 1 1 1", out_valid, locked, err_cnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || locked !== 1'b0 || err_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL async_reset vld %b locked %b err %0d want 0 0 0", out_valid, locked, err_cnt);
        end
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        model_reset();
        p = {$urandom, $urandom, $urandom, $urandom};
        drive(p ^ spread(16'hFFFF), 1'b0, 1'b0);
        n_checks++;
        if (out_data !== p) begin
            n_fail++;
            $display("FAIL post_reset_key got %h want %h", out_data, p);
        end
    endtask

    task automatic test_random();
        logic [127:0] d;
        bit s, idl;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            s   = ($urandom_range(0, 7) == 0);
            idl = ($urandom_range(0, 1) == 1);
            if (idl) begin
                d = clean_idle(s);
                if ($urandom_range(0, 3) == 0) d = d ^ (128'h1 << $urandom_range(0, 127));
            end else begin
                d = {$urandom, $urandom, $urandom, $urandom};
            end
            drive(d, s, idl);
            n_checks++;
            if (out_data !== m_out || locked !== (m_state == 2) || err_cnt !== 8'(m_err)) begin
                n_fail++;
                $display("FAIL random[%0d] data %h locked %b err %0d want %h %b %0d",
                         i, out_data, locked, err_cnt, m_out, m_state == 2, m_err);
            end
        end
    endtask

    task automatic test_err_saturation();
        do_reset();
        for (int r = 0; r < 86; r++) begin
            lock_up();
            for (int j = 0; j < ERR_MAX; j++) drive(clean_idle(1'b0) ^ 128'h2, 1'b0, 1'b1);
        end
        n_checks++;
        if (err_cnt !== 8'hFF || locked !== 1'b0) begin
            n_fail++;
            $display("FAIL err_saturate err %0d locked %b want 255 0", err_cnt, locked);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_seed_sequence();
        test_lock_acquire();
        test_lock_loss();
        test_backpressure();
        test_reseed_locked();
        test_reset_midstream();
        test_random();
        test_err_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pcie_descrambler.md
# pcie_descrambler

Receive-side counterpart to the PCS transmit scrambler: removes the 16-bit LFSR keystream from 128-bit beats arriving from the lane/deskew logic. The block re-seeds on link-layer seed markers and tracks keystream lock against idle beats. It delivers descrambled data through a one-stage registered valid/ready output to the link layer. It sits between RX block alignment and the TLP/DLLP framer.

## Interface
- LOCK_CNT, default 4: consecutive matching idle beats required in VERIFY before declaring lock.
- ERR_MAX, default 3: consecutive mismatching idle beats in LOCKED that force loss of lock.
- clk  input  1  single block clock, all logic on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_data  input  128  scrambled beat.
- in_seed  input  1  qualified by in_valid; this beat is the first beat after keystream reset (uses seed 16'hFFFF).
- in_idle  input  1  qualified by in_valid; beat is an idle beat whose plaintext is 128'h0.
- out_valid  output  1  descrambled beat valid.
- out_ready  input  1  downstream accepts.
- out_data  output  128  descrambled beat.
- locked  output  1  keystream lock indication.
- err_cnt  output  8  saturating count of idle mismatches while LOCKED.

## Operation
- Accept = in_valid && in_ready. Nothing advances or updates without accept.
- Keystream: 16-bit lfsr. Step function next = {lfsr[14:0], lfsr[15]^lfsr[14]}. Keystream word = 8 copies of the 16-bit value.
- Effective key per accepted beat: 16'hFFFF if in_seed, else the current lfsr. After accept, lfsr <= step(effective key).
- Descrambled = in_data ^ {8{effective key}}. It is registered into out_data on accept.
- Beats are forwarded regardless of lock state. The downstream uses locked to qualify them.
- Lock FSM states: SEARCH, VERIFY, LOCKED. Reset state is SEARCH.
  - SEARCH: an accepted in_seed beat -> VERIFY. Match counter is cleared, and set to 1 if that beat is a matching idle beat.
  - VERIFY: an accepted idle beat with descrambled == 0 increments the match counter. The counter reaching LOCK_CNT -> LOCKED.
  - VERIFY: an accepted idle beat that mismatches -> SEARCH.
  - VERIFY: non-idle beats neither count nor reset the match counter.
  - LOCKED: an accepted idle mismatch increments the consecutive-error counter and err_cnt (saturates at 255). An accepted idle match clears the consecutive-error counter. The consecutive-error counter reaching ERR_MAX -> SEARCH.
  - An in_seed beat in VERIFY or LOCKED re-seeds the keystream but does not change state. That beat is still checked if it is idle.
- locked = (state == LOCKED), registered.
- err_cnt clears only on reset.

## Timing
- Reset values: out_valid 0, out_data 0, locked 0, err_cnt 0, lfsr 16'hFFFF, state SEARCH, in_ready 1.
- Latency: one cycle. A beat accepted at edge N appears on out_data/out_valid after edge N.
- in_ready = !out_valid || out_ready (combinational; no bubble at full throughput).
- Under backpressure (out_valid && !out_ready), out_data, lfsr and FSM all hold.
- Throughput: one beat per cycle when out_ready stays high.
- locked rises in the same cycle that out_valid presents the LOCK_CNT-th matching idle beat. It falls likewise with the ERR_MAX-th mismatch.
- Reset mid-operation: all state returns to reset values immediately. Any in-flight output beat is discarded.
- Simultaneous in_seed and in_idle on one beat: the check uses the seed key 16'hFFFF.

## Structure
- Shared package pcie_pcs_pkg: LFSR_SEED = 16'hFFFF, the lfsr_step function (reused by the transmit scrambler), and the desc_state_e enum (SEARCH, VERIFY, LOCKED).
- Natural sub-module: pcie_desc_lock_fsm. It takes an accept strobe, seed, idle and match, and produces locked and err_cnt.
- The datapath, LFSR and output register stay in the top module.

## Test plan
- Seed sequence: accept in_seed beat {8{16'hFFFF}}, then beats {8{16'hFFFE}}, {8{16'hFFFC}}, {8{16'hFFF8}} -> out_data 128'h0 for each, one cycle later.
- Lock acquire: seed beat plus 3 idle beats, all matching, with LOCK_CNT=4 -> locked rises with the 4th output beat. err_cnt stays 0.
- Lock loss: in LOCKED, 3 consecutive idle beats with bit 0 flipped -> err_cnt = 3, locked falls on the 3rd. A later non-seed idle beat does not relock.
- Backpressure: out_ready held low for 5 cycles mid-stream -> in_ready 0, out_data stable, lfsr unchanged. Resuming yields the correct keystream with no skipped or duplicated beat.
- Re-seed in LOCKED: in_seed beat {8{16'hFFFF}} while locked -> out_data 0, locked stays 1, following beat keyed with 16'hFFFE.
- Reset mid-stream: assert rst_n low while out_valid=1 -> out_valid, locked and err_cnt are 0 immediately. A non-seed beat after release is keyed with 16'hFFFF.
